// File: rtl/piano_pkg.sv
// Shared piano definitions: clocking, note count and the per-key debounce state encoding.
package piano_pkg;

    localparam int CLK_HZ              = 50_000_000;
    localparam int DEBOUNCE_MS         = 10;
    localparam int NUM_NOTES           = 7;
    localparam int DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM_ON  = 2'd1,
        ON      = 2'd2,
        ARM_OFF = 2'd3
    } ch_state_t;

    // Width of a key index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/light_key_debounce_if.sv
// Sensor-in / clean-key-out bundle between the light sensors and the tone/display logic.
interface light_key_debounce_if
    import piano_pkg::*;
#(
    parameter int NUM_KEYS = NUM_NOTES,
    parameter int IDX_W    = idx_width(NUM_KEYS)
);
    logic [NUM_KEYS-1:0] light;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [IDX_W-1:0]    active_idx;
    logic                any_active;

    modport master (
        output light,
        input  key_level, key_press, key_release, active_idx, any_active
    );

    modport slave (
        input  light,
        output key_level, key_press, key_release, active_idx, any_active
    );
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser followed by a counting debounce FSM.
module key_debounce_ch
    import piano_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic light,
    output logic key_level,
    output logic key_press,
    output logic key_release
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r, sync2_r;
    ch_state_t        state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             level_r, level_s;
    logic             press_r, press_s;
    logic             release_r, release_s;

    // Synchroniser for the asynchronous sensor input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= light;
            sync2_r <= sync1_r;
        end
    end

    // FSM, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            level_r   <= level_s;
            press_r   <= press_s;
            release_r <= release_s;
        end
    end

    // Next-state logic; the counter holds at CNT_LAST once a level is accepted.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        level_s   = level_r;
        press_s   = 1'b0;
        release_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (sync2_r) begin
                    state_s = ARM_ON;
                    cnt_s   = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            ARM_ON: begin
                if (!sync2_r) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ON;
                    level_s = 1'b1;
                    press_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ON: begin
                if (!sync2_r) begin
                    state_s = ARM_OFF;
                    cnt_s   = '0;
                end else begin
                    state_s = ON;
                end
            end
            ARM_OFF: begin
                if (sync2_r) begin
                    state_s = ON;
                    cnt_s   = '0;
                end else if (cnt_r == CNT_LAST) begin
                    state_s   = IDLE;
                    level_s   = 1'b0;
                    release_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
                level_s = 1'b0;
            end
        endcase
    end

    assign key_level   = level_r;
    assign key_press   = press_r;
    assign key_release = release_r;

endmodule

// File: rtl/light_key_debounce.sv
// Debounces all light-sensor keys and reports the lowest active key, registered behind key_level.
module light_key_debounce
    import piano_pkg::*;
#(
    parameter int NUM_KEYS        = NUM_NOTES,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    light_key_debounce_if.slave  bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int IDX_W = idx_width(NUM_KEYS);

    logic [NUM_KEYS-1:0] level_s;
    logic [NUM_KEYS-1:0] press_s;
    logic [NUM_KEYS-1:0] release_s;
    logic [IDX_W-1:0]    idx_s, idx_r;
    logic                any_s, any_r;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .light       (bus.light[k]),
            .key_level   (level_s[k]),
            .key_press   (press_s[k]),
            .key_release (release_s[k])
        );
    end

    // Lowest-index priority encode; scanning downward lets the lowest set bit win.
    always_comb begin
        idx_s = '0;
        any_s = |level_s;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (level_s[i]) begin
                idx_s = IDX_W'(i);
            end else begin
                idx_s = idx_s;
            end
        end
    end

    // Encoder output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r <= '0;
            any_r <= 1'b0;
        end else begin
            idx_r <= idx_s;
            any_r <= any_s;
        end
    end

    assign bus.key_level   = level_s;
    assign bus.key_press   = press_s;
    assign bus.key_release = release_s;
    assign bus.active_idx  = idx_r;
    assign bus.any_active  = any_r;

endmodule

// File: tb/tb_light_key_debounce.sv
// Directed bench for light_key_debounce with DEBOUNCE_CYCLES=8, NUM_KEYS=7.
module tb_light_key_debounce;
    localparam int NK = 7;
    localparam int DC = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [NK-1:0] acc_level, acc_press, acc_release;
    int   press_cnt, release_cnt;

    light_key_debounce_if #(.NUM_KEYS(NK)) bus ();

    light_key_debounce #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_acc();
        acc_level   = '0;
        acc_press   = '0;
        acc_release = '0;
        press_cnt   = 0;
        release_cnt = 0;
    endtask

    task automatic run_acc(input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            acc_level   = acc_level | bus.key_level;
            acc_press   = acc_press | bus.key_press;
            acc_release = acc_release | bus.key_release;
            press_cnt   = press_cnt + $countones(bus.key_press);
            release_cnt = release_cnt + $countones(bus.key_release);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.light = 7'h7F;
        clear_acc();

        // 1: reset with all keys covered, then full debounce
        step(3);
        check("rst_level", 32'(bus.key_level), 32'h0);
        check("rst_press", 32'(bus.key_press), 32'h0);
        check("rst_release", 32'(bus.key_release), 32'h0);
        check("rst_idx", 32'(bus.active_idx), 32'h0);
        check("rst_any", 32'(bus.any_active), 32'h0);
        rst = 1'b0;
        step(10);
        check("t1_level_early", 32'(bus.key_level), 32'h0);
        step(1);
        check("t1_level", 32'(bus.key_level), 32'h7F);
        check("t1_press", 32'(bus.key_press), 32'h7F);
        check("t1_any_lag", 32'(bus.any_active), 32'h0);
        step(1);
        check("t1_press_end", 32'(bus.key_press), 32'h0);
        check("t1_any", 32'(bus.any_active), 32'h1);
        check("t1_idx", 32'(bus.active_idx), 32'h0);
        bus.light = 7'h00;
        step(10);
        check("t1_rel_early", 32'(bus.key_release), 32'h0);
        step(1);
        check("t1_release", 32'(bus.key_release), 32'h7F);
        check("t1_level_off", 32'(bus.key_level), 32'h0);
        step(2);
        check("t1_any_off", 32'(bus.any_active), 32'h0);

        // 2: 8-cycle glitch rejected, 9-cycle pulse accepted
        clear_acc();
        bus.light[3] = 1'b1;
        run_acc(8);
        bus.light[3] = 1'b0;
        run_acc(20);
        check("t2_glitch_level", 32'(acc_level), 32'h0);
        check("t2_glitch_press", 32'(acc_press), 32'h0);
        check("t2_glitch_rel", 32'(acc_release), 32'h0);
        clear_acc();
        bus.light[3] = 1'b1;
        run_acc(9);
        bus.light[3] = 1'b0;
        run_acc(25);
        check("t2_accept_level", 32'(acc_level), 32'h08);
        check("t2_accept_presses", 32'(press_cnt), 32'd1);
        check("t2_accept_pressbit", 32'(acc_press), 32'h08);

        // 3: short low dip ignored, long drop released after 11 cycles
        bus.light[1] = 1'b1;
        step(13);
        check("t3_level_on", 32'(bus.key_level), 32'h02);
        clear_acc();
        bus.light[1] = 1'b0;
        run_acc(5);
        bus.light[1] = 1'b1;
        run_acc(25);
        check("t3_dip_rel", 32'(release_cnt), 32'd0);
        check("t3_dip_level", 32'(bus.key_level), 32'h02);
        bus.light[1] = 1'b0;
        clear_acc();
        run_acc(10);
        check("t3_rel_early", 32'(release_cnt), 32'd0);
        step(1);
        check("t3_release", 32'(bus.key_release), 32'h02);
        clear_acc();
        run_acc(9);
        bus.light[1] = 1'b1;
        run_acc(1);
        bus.light[1] = 1'b0;
        check("t3_rel_once", 32'(release_cnt), 32'd0);
        check("t3_level_off", 32'(bus.key_level), 32'h0);

        // 4: simultaneous presses, priority encoding
        bus.light[5] = 1'b1;
        bus.light[2] = 1'b1;
        step(11);
        check("t4_press", 32'(bus.key_press), 32'h24);
        step(1);
        check("t4_idx2", 32'(bus.active_idx), 32'd2);
        check("t4_any", 32'(bus.any_active), 32'h1);
        bus.light[2] = 1'b0;
        step(11);
        check("t4_rel2", 32'(bus.key_release), 32'h04);
        step(1);
        check("t4_idx5", 32'(bus.active_idx), 32'd5);
        bus.light[5] = 1'b0;
        step(12);
        check("t4_any_off", 32'(bus.any_active), 32'h0);
        check("t4_idx_off", 32'(bus.active_idx), 32'd0);

        // 5: reset while key held clears level silently and forces re-debounce
        bus.light[4] = 1'b1;
        step(12);
        check("t5_level_on", 32'(bus.key_level), 32'h10);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t5_rst_level", 32'(bus.key_level), 32'h0);
        check("t5_rst_release", 32'(bus.key_release), 32'h0);
        clear_acc();
        run_acc(10);
        check("t5_no_release", 32'(release_cnt), 32'd0);
        check("t5_level_early", 32'(acc_level), 32'h0);
        step(1);
        check("t5_level_back", 32'(bus.key_level), 32'h10);
        check("t5_press_back", 32'(bus.key_press), 32'h10);
        bus.light[4] = 1'b0;
        step(13);

        // 6: toggling input every cycle never produces a key event
        clear_acc();
        for (int i = 0; i < 100; i++) begin
            bus.light[6] = ~bus.light[6];
            run_acc(1);
        end
        bus.light[6] = 1'b0;
        run_acc(12);
        check("t6_level", 32'(acc_level), 32'h0);
        check("t6_press", 32'(acc_press), 32'h0);
        check("t6_release", 32'(acc_release), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
